// File: rtl/n64_vdemux.sv
// n64_vdemux: demultiplexes the N64 7-bit video bus into a registered {sync, R, G, B} pixel word.
// Optional macro N64_VDEMUX_BLANK_EN forces RGB to zero on commits inside horizontal or vertical sync.
module n64_vdemux #(
  parameter int color_width = 7
) (
  input  logic                       nCLK,
  input  logic                       RST,
  input  logic                       nDSYNC,
  input  logic [color_width-1:0]     D_i,
  input  logic [4:0]                 vinfo,
  input  logic                       deblur_en,
  output logic [3:0]                 Sync_pre,
  output logic [3:0]                 Sync_cur,
  output logic [4+3*color_width-1:0] vdata_o,
  output logic                       dvalid_o
);
  localparam int rgb_w = 3*color_width;
  logic [color_width-1:0] r, g, b;
  logic [rgb_w-1:0] held_rgb, rgb_commit;
  logic [1:0] data_cnt;
  logic n64_480i, blurry_pixel_pos, hold, blank, unused_vmode;
  assign data_cnt         = vinfo[4:3];
  assign n64_480i         = vinfo[2];
  assign unused_vmode     = vinfo[1];
  assign blurry_pixel_pos = vinfo[0];
  assign hold             = deblur_en & ~n64_480i & blurry_pixel_pos;
`ifdef N64_VDEMUX_BLANK_EN
  // Sync_cur is the nibble being committed: {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  assign blank = ~(Sync_cur[3] & Sync_cur[1]);
`else
  assign blank = 1'b0;
`endif
  assign rgb_commit = blank ? '0 : hold ? held_rgb : {r, g, b};
  always_ff @(negedge nCLK or posedge RST) begin
    if (RST) begin
      Sync_pre <= 4'hF;
      Sync_cur <= 4'hF;
      vdata_o  <= {4'hF, {rgb_w{1'b0}}};
      dvalid_o <= 1'b0;
      r        <= '0;
      g        <= '0;
      b        <= '0;
      held_rgb <= '0;
    end else begin
      dvalid_o <= ~nDSYNC;
      if (!nDSYNC) begin
        Sync_pre <= Sync_cur;
        Sync_cur <= D_i[3:0];
        vdata_o  <= {Sync_cur, rgb_commit};
        if (!hold && !blank) held_rgb <= {r, g, b};
      end else begin
        if (data_cnt == 2'd1) r <= D_i;
        if (data_cnt == 2'd2) g <= D_i;
        if (data_cnt == 2'd3) b <= D_i;
      end
    end
  end
endmodule

// File: tb/tb_n64_vdemux.sv
// tb_n64_vdemux: directed self-checking bench for n64_vdemux with hand-computed pixel words.
module tb_n64_vdemux;
  logic nCLK = 1'b1, RST = 1'b0, nDSYNC = 1'b1, deblur_en = 1'b0, i480 = 1'b0;
  logic [6:0] D_i = '0;
  logic [4:0] vinfo = '0;
  logic [3:0] Sync_pre, Sync_cur;
  logic [24:0] vdata_o;
  logic dvalid_o;
  int checks = 0, errors = 0;

  n64_vdemux dut (
    .nCLK(nCLK), .RST(RST), .nDSYNC(nDSYNC), .D_i(D_i), .vinfo(vinfo),
    .deblur_en(deblur_en), .Sync_pre(Sync_pre), .Sync_cur(Sync_cur),
    .vdata_o(vdata_o), .dvalid_o(dvalid_o)
  );

  always #5 nCLK = ~nCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic nd, input logic [6:0] d, input logic [1:0] cnt, input logic blur);
    @(posedge nCLK);
    nDSYNC = nd;
    D_i    = d;
    vinfo  = {cnt, i480, 1'b0, blur};
    @(negedge nCLK);
    #1;
  endtask

  function automatic logic [24:0] pix(input logic [3:0] s, input logic [6:0] r, g, b);
`ifdef N64_VDEMUX_BLANK_EN
    if (!(s[3] && s[1])) return {s, 21'h0};
`endif
    return {s, r, g, b};
  endfunction

  initial begin
    #2 RST = 1'b1;
    #1;
    chk("rst_pre", Sync_pre, 4'hF);
    chk("rst_cur", Sync_cur, 4'hF);
    chk("rst_vdata", vdata_o, 25'h1E00000);
    chk("rst_dvalid", dvalid_o, 1'b0);
    #4 RST = 1'b0;
    // basic demux
    step(0, 7'h0B, 0, 0);
    chk("first_commit", vdata_o, pix(4'hF, 0, 0, 0));
    chk("first_dvalid", dvalid_o, 1'b1);
    step(1, 7'h11, 1, 0);
    chk("dvalid_low", dvalid_o, 1'b0);
    step(1, 7'h22, 2, 0);
    step(1, 7'h33, 3, 0);
    chk("hold_vdata", vdata_o, pix(4'hF, 0, 0, 0));
    step(0, 7'h0F, 0, 0);
    chk("basic_vdata", vdata_o, pix(4'hB, 7'h11, 7'h22, 7'h33));
    chk("basic_dvalid", dvalid_o, 1'b1);
    chk("basic_pre", Sync_pre, 4'hB);
    chk("basic_cur", Sync_cur, 4'hF);
    step(1, 7'h44, 1, 0);
    chk("basic_pulse_end", dvalid_o, 1'b0);
    // de-blur
    deblur_en = 1'b1;
    step(1, 7'h01, 1, 0);
    step(1, 7'h02, 2, 0);
    step(1, 7'h03, 3, 0);
    step(0, 7'h0E, 0, 0);
    chk("deblur_a", vdata_o, pix(4'hF, 1, 2, 3));
    step(1, 7'h04, 1, 1);
    step(1, 7'h05, 2, 1);
    step(1, 7'h06, 3, 1);
    step(0, 7'h0D, 0, 1);
    chk("deblur_b_held", vdata_o, pix(4'hE, 1, 2, 3));
    chk("deblur_b_dvalid", dvalid_o, 1'b1);
    i480 = 1'b1;
    step(0, 7'h0C, 0, 1);
    chk("deblur_480i", vdata_o, pix(4'hD, 4, 5, 6));
    i480 = 1'b0;
    step(0, 7'h0A, 0, 1);
    chk("deblur_held_upd", vdata_o, pix(4'hC, 4, 5, 6));
    // long phase with data_cnt=0
    deblur_en = 1'b0;
    step(1, 7'h21, 1, 0);
    step(1, 7'h42, 2, 0);
    step(1, 7'h63, 3, 0);
    for (int i = 0; i < 6; i++) step(1, 7'(7'h7F ^ i), 0, 0);
    chk("long_dvalid", dvalid_o, 1'b0);
    step(0, 7'h09, 0, 0);
    chk("long_vdata", vdata_o, pix(4'hA, 7'h21, 7'h42, 7'h63));
    // back-to-back commits
    step(0, 7'h07, 0, 0);
    chk("b2b_1_vdata", vdata_o, pix(4'h9, 7'h21, 7'h42, 7'h63));
    chk("b2b_1_dvalid", dvalid_o, 1'b1);
    step(0, 7'h05, 0, 0);
    chk("b2b_2_vdata", vdata_o, pix(4'h7, 7'h21, 7'h42, 7'h63));
    chk("b2b_2_dvalid", dvalid_o, 1'b1);
    chk("b2b_pre", Sync_pre, 4'h7);
    chk("b2b_cur", Sync_cur, 4'h5);
    // partial pixel keeps stale G/B
    step(1, 7'h55, 1, 0);
    step(0, 7'h06, 0, 0);
    chk("partial", vdata_o, pix(4'h5, 7'h55, 7'h42, 7'h63));
    // mid-pixel reset
    step(1, 7'h12, 1, 0);
    step(0, 7'h0E, 0, 0);
    chk("pre_rst_vdata", vdata_o, pix(4'h6, 7'h12, 7'h42, 7'h63));
    D_i = 7'h2A;
    RST = 1'b1;
    #1;
    D_i = 7'h15;
    chk("mid_rst_pre", Sync_pre, 4'hF);
    chk("mid_rst_cur", Sync_cur, 4'hF);
    chk("mid_rst_vdata", vdata_o, 25'h1E00000);
    chk("mid_rst_dvalid", dvalid_o, 1'b0);
    #1 RST = 1'b0;
    step(0, 7'h03, 0, 0);
    chk("post_rst_commit", vdata_o, pix(4'hF, 0, 0, 0));
    // sync periods: RGB passes unless blanking is built in
    step(1, 7'h09, 1, 0);
    step(1, 7'h09, 2, 0);
    step(1, 7'h09, 3, 0);
    step(0, 7'h0B, 0, 0);
    chk("sync3_rgb", vdata_o, pix(4'h3, 9, 9, 9));
    step(0, 7'h0F, 0, 0);
    chk("syncB_rgb", vdata_o, pix(4'hB, 9, 9, 9));
    step(0, 7'h05, 0, 0);
    chk("syncF_rgb", vdata_o, pix(4'hF, 9, 9, 9));
    step(0, 7'h0F, 0, 0);
    chk("sync5_rgb", vdata_o, pix(4'h5, 9, 9, 9));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
